// File: rtl/secure_pkg.sv
// Shared definitions for the secure GCD/RSA datapath blocks.
// Holds the mul_add state encoding and its fixed latency for schedulers.
package secure_pkg;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_CALC = 2'd1,
    MA_DONE = 2'd2
  } ma_state_t;

  // Cycles from the accepting edge to the finish pulse, for any operands.
  function automatic int MUL_ADD_LATENCY(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mul_add.sv
// Constant-time dividend = quotient * divisor + remainder.
// Every CALC step adds the masked multiplicand, so latency never depends on operand values.
module mul_add
  import secure_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  output logic [2*WIDTH-1:0]   dividend,
  output logic                 fits,
  output logic                 busy,
  output logic                 finish
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  ma_state_t            state;
  logic [WIDTH-1:0]     q_reg;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        step;
  logic [2*WIDTH-1:0]   addend;

  // The quotient bit masks the addend instead of gating the add itself.
  assign addend = mcand & {(2*WIDTH){q_reg[step]}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MA_IDLE;
      q_reg    <= '0;
      mcand    <= '0;
      acc      <= '0;
      step     <= '0;
      dividend <= '0;
      fits     <= 1'b1;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        MA_IDLE: begin
          if (start) begin
            state <= MA_CALC;
            q_reg <= quotient;
            mcand <= {{WIDTH{1'b0}}, divisor};
            acc   <= {{WIDTH{1'b0}}, remainder};
            step  <= '0;
            busy  <= 1'b1;
          end
        end
        MA_CALC: begin
          acc   <= acc + addend;
          mcand <= mcand << 1;
          if (step == LAST_STEP) begin
            state <= MA_DONE;
          end else begin
            step <= step + CW'(1);
          end
        end
        MA_DONE: begin
          dividend <= acc;
          fits     <= (acc[2*WIDTH-1:WIDTH] == '0);
          finish   <= 1'b1;
          busy     <= 1'b0;
          state    <= MA_IDLE;
        end
        default: begin
          state <= MA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add.sv
// Self-checking bench for mul_add at WIDTH=8 and WIDTH=16.
// Expected results come from plain integer arithmetic, including a divide/rebuild round trip.
module tb_mul_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  q8, d8, r8;
  logic [15:0] q16, d16, r16;
  logic [15:0] div8;
  logic [31:0] div16;
  logic        fits8, fits16, busy8, busy16, fin8, fin16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_add #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .quotient  (q8),
    .divisor   (d8),
    .remainder (r8),
    .dividend  (div8),
    .fits      (fits8),
    .busy      (busy8),
    .finish    (fin8)
  );

  mul_add #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .start     (start16),
    .quotient  (q16),
    .divisor   (d16),
    .remainder (r16),
    .dividend  (div16),
    .fits      (fits16),
    .busy      (busy16),
    .finish    (fin16)
  );

  function automatic logic [63:0] obsDiv(input bit wide);
    return wide ? 64'(div16) : 64'(div8);
  endfunction

  function automatic logic obsFits(input bit wide);
    return wide ? fits16 : fits8;
  endfunction

  function automatic logic obsBusy(input bit wide);
    return wide ? busy16 : busy8;
  endfunction

  function automatic logic obsFin(input bit wide);
    return wide ? fin16 : fin8;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveInputs(input bit wide, input logic [15:0] q, input logic [15:0] d,
                             input logic [15:0] r, input logic s);
    if (wide) begin
      q16 = q; d16 = d; r16 = r; start16 = s;
    end else begin
      q8 = q[7:0]; d8 = d[7:0]; r8 = r[7:0]; start8 = s;
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge,
  // with operands scrambled so an unlatched operand would corrupt the result.
  task automatic applyStimulus(input bit wide, input logic [15:0] q, input logic [15:0] d,
                               input logic [15:0] r);
    driveInputs(wide, q, d, r, 1'b1);
    @(negedge clk);
    driveInputs(wide, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic waitFinish(input bit wide, output int cycles);
    cycles = 0;
    while (obsFin(wide) !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic runAndCheck(input string tag, input bit wide, input logic [15:0] q,
                             input logic [15:0] d, input logic [15:0] r,
                             input logic [63:0] expDiv);
    int w;
    int cyc;
    logic expFits;
    w = wide ? 16 : 8;
    expFits = ((expDiv >> w) == 64'd0);
    applyStimulus(wide, q, d, r);
    checkOutput({tag, "_busy"}, 64'(obsBusy(wide)), 64'd1);
    waitFinish(wide, cyc);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(w + 1));
    checkOutput({tag, "_dividend"}, obsDiv(wide), expDiv);
    checkOutput({tag, "_fits"}, 64'(obsFits(wide)), 64'(expFits));
    @(negedge clk);
    checkOutput({tag, "_finish_drop"}, 64'(obsFin(wide)), 64'd0);
    checkOutput({tag, "_busy_drop"}, 64'(obsBusy(wide)), 64'd0);
  endtask

  initial begin
    int cyc;
    int finCount;
    logic [63:0] mask, q, d, r, n, e;
    int w;

    rst = 1'b1;
    driveInputs(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    driveInputs(1'b1, 16'd0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset_dividend", obsDiv(s[0]), 64'd0);
      checkOutput("reset_fits", 64'(obsFits(s[0])), 64'd1);
      checkOutput("reset_busy", 64'(obsBusy(s[0])), 64'd0);
      checkOutput("reset_finish", 64'(obsFin(s[0])), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed operand cases");
    runAndCheck("basic", 1'b0, 16'd13, 16'd7, 16'd5, 64'd96);
    runAndCheck("max8", 1'b0, 16'd255, 16'd255, 16'd255, 64'hFF00);
    runAndCheck("zero8", 1'b0, 16'd0, 16'd0, 16'd0, 64'd0);
    runAndCheck("max16", 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 64'hFFFF0000);

    $display("[TB] start while busy");
    applyStimulus(1'b0, 16'd10, 16'd20, 16'd3);
    finCount = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3 || k == 5) driveInputs(1'b0, 16'd200, 16'd200, 16'd200, 1'b1);
      else start8 = 1'b0;
      @(negedge clk);
      if (fin8 === 1'b1) finCount++;
    end
    start8 = 1'b0;
    checkOutput("ignore_finish_count", 64'(finCount), 64'd1);
    checkOutput("ignore_dividend", obsDiv(1'b0), 64'd203);
    checkOutput("ignore_busy", 64'(busy8), 64'd0);

    $display("[TB] reset mid-calculation");
    applyStimulus(1'b0, 16'd13, 16'd7, 16'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 64'(busy8), 64'd0);
    checkOutput("midrst_dividend", obsDiv(1'b0), 64'd0);
    checkOutput("midrst_fits", 64'(fits8), 64'd1);
    checkOutput("midrst_finish", 64'(fin8), 64'd0);
    finCount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fin8 === 1'b1) finCount++;
    end
    checkOutput("midrst_no_finish", 64'(finCount), 64'd0);

    $display("[TB] accept in the finish cycle");
    applyStimulus(1'b0, 16'd13, 16'd7, 16'd5);
    waitFinish(1'b0, cyc);
    checkOutput("b2b_first_latency", 64'(cyc), 64'd9);
    checkOutput("b2b_first_dividend", obsDiv(1'b0), 64'd96);
    driveInputs(1'b0, 16'd2, 16'd3, 16'd1, 1'b1);
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("b2b_accepted_busy", 64'(busy8), 64'd1);
    checkOutput("b2b_held_dividend", obsDiv(1'b0), 64'd96);
    waitFinish(1'b0, cyc);
    checkOutput("b2b_second_latency", 64'(cyc), 64'd9);
    checkOutput("b2b_second_dividend", obsDiv(1'b0), 64'd7);
    checkOutput("b2b_second_fits", 64'(fits8), 64'd1);
    @(negedge clk);

    $display("[TB] random regression");
    for (int wsel = 0; wsel < 2; wsel++) begin
      for (int i = 0; i < 1000; i++) begin
        w = (wsel == 1) ? 16 : 8;
        mask = (64'd1 << w) - 64'd1;
        if ($urandom_range(0, 1) == 1) begin
          n = 64'($urandom) & mask;
          d = 64'($urandom) & mask;
          if (d == 64'd0) d = 64'd1;
          q = n / d;
          r = n % d;
          e = n;
        end else begin
          q = 64'($urandom) & mask;
          d = 64'($urandom) & mask;
          r = 64'($urandom) & mask;
          e = q * d + r;
        end
        runAndCheck($sformatf("rand%0d_%0d", w, i), wsel[0], q[15:0], d[15:0], r[15:0], e);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
